pipeline_hazard_ctrl: RTL

Parametrised hazard, forwarding and multi-cycle-execute control unit for the 5-stage RISC-V pipeline. It replaces the separate single-cycle hazard-detection and forwarding logic with one block. It adds an EX-stage hold state machine for multi-cycle operations (MUL/DIV), x0-aware forwarding, branch-flush generation, and saturating stall/flush performance counters. It sits beside the datapath and drives the enables, bubbles, flushes and forwarding-mux selects of the pipeline registers.

---
 rtl/pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard, forwarding and multi-cycle-execute control for a 5-stage RISC-V
//   pipeline. Generates PC/IF-ID holds, ID/EX and EX/MEM bubbles, branch
//   flushes, EX operand forwarding selects, and saturating stall/flush
//   event counters. A two-state FSM holds EX for MC_LAT cycles per MUL/DIV.
//
//   state  | meaning
//   IDLE   | no multi-cycle op occupying EX beyond its first cycle
//   BUSY   | multi-cycle op in EX, r_cnt more hold cycles remain
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   i_cnt_clr                     sync clear of both event counters
//   i_id_rs1/2, i_id_rs1/2_used   ID sources and read qualifiers
//   i_ex_rs1/2, i_ex_rd           EX sources / destination
//   i_ex_valid, i_ex_reg_write,
//   i_ex_mem_read, i_ex_is_mc     EX instruction attributes
//   i_ex_redirect                 EX resolved taken branch / jump
//   i_mem_rd, i_wb_rd,
//   i_mem_reg_write, i_wb_reg_write  later-stage destinations
//   o_stall_if, o_stall_id        hold PC, hold IF/ID
//   o_bubble_ex, o_bubble_mem     bubble into ID/EX, EX/MEM
//   o_flush_if_id, o_flush_id_ex  squash IF/ID, ID/EX
//   o_fwd_a_sel, o_fwd_b_sel      00 RF, 01 WB result, 10 MEM alu result
//   o_mc_busy                     FSM in BUSY (registered)
//   o_stall_cnt, o_flush_cnt      saturating event counters

module pipeline_hazard_ctrl #(
  parameter int RF_ADDR = 5,
  parameter int MC_LAT  = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cnt_clr,
  input  logic [RF_ADDR-1:0] i_id_rs1,
  input  logic [RF_ADDR-1:0] i_id_rs2,
  input  logic               i_id_rs1_used,
  input  logic               i_id_rs2_used,
  input  logic [RF_ADDR-1:0] i_ex_rs1,
  input  logic [RF_ADDR-1:0] i_ex_rs2,
  input  logic [RF_ADDR-1:0] i_ex_rd,
  input  logic               i_ex_valid,
  input  logic               i_ex_reg_write,
  input  logic               i_ex_mem_read,
  input  logic               i_ex_is_mc,
  input  logic               i_ex_redirect,
  input  logic [RF_ADDR-1:0] i_mem_rd,
  input  logic [RF_ADDR-1:0] i_wb_rd,
  input  logic               i_mem_reg_write,
  input  logic               i_wb_reg_write,
  output logic               o_stall_if,
  output logic               o_stall_id,
  output logic               o_bubble_ex,
  output logic               o_bubble_mem,
  output logic               o_flush_if_id,
  output logic               o_flush_id_ex,
  output logic [1:0]         o_fwd_a_sel,
  output logic [1:0]         o_fwd_b_sel,
  output logic               o_mc_busy,
  output logic [CNT_W-1:0]   o_stall_cnt,
  output logic [CNT_W-1:0]   o_flush_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_hold;
  logic               w_lu;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  // A load's write-enable is implied by the load itself, so ex_reg_write
  // plays no part in the load-use check.
  logic w_unused;
  assign w_unused = i_ex_reg_write;

  function automatic logic [1:0] fwd_sel(input logic [RF_ADDR-1:0] src);
    if (i_mem_reg_write && (i_mem_rd == src) && (i_mem_rd != '0))
      return 2'b10;
    else if (i_wb_reg_write && (i_wb_rd == src) && (i_wb_rd != '0))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_lu = i_ex_valid && i_ex_mem_read && (i_ex_rd != '0) &&
                ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                 (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));

  // Hold covers the entry cycle plus MC_LAT-2 BUSY cycles; the final BUSY
  // cycle (cnt==0) lets the op leave EX without re-triggering on it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_ex_valid && i_ex_is_mc) begin
          w_hold      = 1'b1;
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_W'(MC_LAT - 2);
        end
      end
      S_BUSY: begin
        if (r_cnt != '0) begin
          w_hold    = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_mc_busy = (r_state == S_BUSY);

  // Outputs are forced low while reset is asserted, independent of inputs.
  always_comb begin
    o_stall_if    = 1'b0;
    o_stall_id    = 1'b0;
    o_bubble_ex   = 1'b0;
    o_bubble_mem  = 1'b0;
    o_flush_if_id = 1'b0;
    o_flush_id_ex = 1'b0;
    o_fwd_a_sel   = 2'b00;
    o_fwd_b_sel   = 2'b00;
    if (rst_n) begin
      if (w_hold) begin
        o_stall_if   = 1'b1;
        o_stall_id   = 1'b1;
        o_bubble_mem = 1'b1;
      end else if (i_ex_redirect) begin
        // ID holds a wrong-path instruction, so any load-use is moot.
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
      end else if (w_lu) begin
        o_stall_if  = 1'b1;
        o_stall_id  = 1'b1;
        o_bubble_ex = 1'b1;
      end
      o_fwd_a_sel = fwd_sel(i_ex_rs1);
      o_fwd_b_sel = fwd_sel(i_ex_rs2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (o_stall_if && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (o_flush_if_id && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
